// File: rtl/mem_arb.sv
// mem_arb: arbitrates a fetch port (IF) and a load/store port (MEM) onto a
// single 8-bit RAM, moving one byte per cycle.
//   clk, rst           clock, asynchronous active-low reset
//   if_req/if_addr     fetch request (always 4 bytes), abortable by dropping if_req
//   if_data/if_done    fetched word (little-endian) and one-cycle done pulse
//   mem_req/mem_we     load/store request and direction
//   mem_addr/mem_len   base byte address, size (00 byte, 01 half, 1x word)
//   mem_wdata          store data, sent LSB first
//   mem_rdata/mem_done zero-extended load data and one-cycle done pulse
//   ram_addr/ram_we/ram_wdata/ram_rdata  byte RAM port, read data one cycle late
//   stall_o            pipeline stall while any request is still outstanding
module mem_arb #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              stall_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_MEM = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       if_data_q, if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;

  logic [2:0] k_m1;
  logic       tail;
  logic       drive;

  assign k_m1  = k_q - 3'd1;
  // Reads run one cycle past the last address (k == n) to catch the late byte.
  assign tail  = (state_q == S_RUN) && !we_q && (k_q == n_q);
  assign drive = (state_q == S_RUN) && !tail;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    n_d         = n_q;
    k_d         = k_q;
    base_d      = base_q;
    data_d      = data_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          state_d = S_RUN;
          owner_d = OWN_MEM;
          we_d    = mem_we;
          n_d     = (mem_len == 2'b00) ? 3'd1 : (mem_len == 2'b01) ? 3'd2 : 3'd4;
          k_d     = '0;
          base_d  = mem_addr;
          data_d  = '0;
        end else if (if_req) begin
          state_d = S_RUN;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          n_d     = 3'd4;
          k_d     = '0;
          base_d  = if_addr;
          data_d  = '0;
        end
      end
      S_RUN: begin
        if (owner_q == OWN_IF && !if_req) begin
          state_d = S_IDLE;
        end else if (we_q) begin
          if (k_q == n_q - 3'd1) state_d = S_DONE;
          else                   k_d     = k_q + 3'd1;
        end else begin
          if (k_q != 3'd0) begin
            for (int unsigned i = 0; i < 4; i++) begin
              if (k_m1 == i[2:0]) data_d[8*i +: 8] = ram_rdata;
            end
          end
          if (k_q == n_q) begin
            state_d = S_DONE;
            // Result is published only on completion so an aborted fetch
            // leaves the previous if_data intact.
            if (owner_q == OWN_MEM) mem_rdata_d = data_d;
            else                    if_data_d   = data_d;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      we_q        <= 1'b0;
      n_q         <= '0;
      k_q         <= '0;
      base_q      <= '0;
      data_q      <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      n_q         <= n_d;
      k_q         <= k_d;
      base_q      <= base_d;
      data_q      <= data_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (drive) begin
      ram_addr = base_q + ADDR_W'(k_q);
      ram_we   = we_q;
      if (we_q) begin
        case (k_q[1:0])
          2'd0:    ram_wdata = mem_wdata[7:0];
          2'd1:    ram_wdata = mem_wdata[15:8];
          2'd2:    ram_wdata = mem_wdata[23:16];
          default: ram_wdata = mem_wdata[31:24];
        endcase
      end
    end
  end

  assign if_done   = (state_q == S_DONE) && (owner_q == OWN_IF);
  assign mem_done  = (state_q == S_DONE) && (owner_q == OWN_MEM);
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign stall_o   = (if_req & ~if_done) | (mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: table-driven and randomized checks of mem_arb against a
// byte-array memory model, plus hand-written collision, abort and reset cases.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        stall_o;

  mem_arb #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Byte RAM attached to the DUT (4 KiB, aliased on the low 12 address bits).
  logic [7:0]  ram [4096];
  logic        clr, pl_en;
  logic [11:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
    end else if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (ram_we) begin
      ram[ram_addr[11:0]] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr[11:0]];
  end

  // Reference memory contents, updated at transaction level.
  logic [7:0]  mdl [4096];
  logic [31:0] exp_if, exp_mem;
  int unsigned n_vec, n_fail;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int unsigned exp_lat;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned len_bytes(input bit is_mem, input logic [1:0] len);
    if (!is_mem) return 4;
    case (len)
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input int unsigned n);
    logic [31:0] r, a;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      a = addr + i;
      r = r | ({24'h0, mdl[a[11:0]]} << (8 * i));
    end
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] wd, input int unsigned n);
    logic [31:0] a;
    for (int unsigned i = 0; i < n; i++) begin
      a = addr + i;
      mdl[a[11:0]] = wd[8*i +: 8];
    end
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    mdl[a] = d;
  endtask

  // Issue one request from IDLE (called #1 after an edge), follow it to done.
  task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int unsigned exp_lat);
    int unsigned n, c;
    bit seen;
    n = len_bytes(is_mem, len);
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    c = 0; seen = 1'b0;
    while (!seen && c < 16) begin
      @(negedge clk);
      if (c == 1) chk("stall_busy", 32'(stall_o), 32'd1);
      if (c >= 1 && c <= n) begin
        chk("ram_addr", ram_addr, addr + c - 1);
        chk("ram_we", 32'(ram_we), 32'(is_mem & we));
        if (is_mem && we) chk("ram_wdata", 32'(ram_wdata), (wdata >> (8 * (c - 1))) & 32'hFF);
      end
      if (is_mem ? mem_done : if_done) begin
        seen = 1'b1;
        chk("latency", c, exp_lat);
        chk("other_done", 32'(is_mem ? if_done : mem_done), 32'd0);
        chk("stall_done", 32'(stall_o), 32'd0);
        if (is_mem) begin
          chk("mem_rdata", mem_rdata, exp_data);
          chk("if_data_hold", if_data, exp_if);
        end else begin
          chk("if_data", if_data, exp_data);
          chk("mem_rdata_hold", mem_rdata, exp_mem);
        end
      end else begin
        chk("early_done", 32'(if_done | mem_done), 32'd0);
      end
      @(posedge clk); #1;
      c++;
    end
    if (!seen) chk("done_timeout", c, exp_lat);
    mem_req = 1'b0;
    if_req  = 1'b0;
    if (is_mem && we) model_write(addr, wdata, n);
    if (is_mem && !we) exp_mem = exp_data;
    if (!is_mem) exp_if = exp_data;
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_len = '0; mem_wdata = '0;
    clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    exp_if = '0; exp_mem = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;

    tbl[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,          32'h0010_0513, 6};
    tbl[1] = '{1'b1, 1'b0, 2'b00, 32'h0000_0040, 32'h0,          32'h0000_0080, 3};
    tbl[2] = '{1'b1, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,          32'h0000_1234, 4};
    tbl[3] = '{1'b1, 1'b1, 2'b10, 32'h0000_0200, 32'hDEAD_BEEF,  32'h0000_1234, 5};
    tbl[4] = '{1'b1, 1'b0, 2'b11, 32'h0000_0200, 32'h0,          32'hDEAD_BEEF, 6};
    tbl[5] = '{1'b1, 1'b1, 2'b01, 32'h0000_07FE, 32'hCAFE_F00D,  32'hDEAD_BEEF, 3};
    tbl[6] = '{1'b1, 1'b0, 2'b10, 32'h0000_07FE, 32'h0,          32'h0000_F00D, 6};
    tbl[7] = '{1'b1, 1'b1, 2'b00, 32'h0000_0010, 32'h0000_00AB,  32'h0000_F00D, 2};
    tbl[8] = '{1'b1, 1'b0, 2'b01, 32'h0000_0010, 32'h0,          32'h0000_00AB, 4};
    tbl[9] = '{1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0,          32'h0012_3400, 6};

    @(posedge clk); #1;
    clr = 1'b0;
    preload(12'h100, 8'h13); preload(12'h101, 8'h05);
    preload(12'h102, 8'h10); preload(12'h103, 8'h00);
    preload(12'h040, 8'h80);
    preload(12'hFFF, 8'h34); preload(12'h000, 8'h12);

    // Outputs while held in reset.
    chk("rst_ram_addr", ram_addr, 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_if_done", 32'(if_done), 32'h0);
    chk("rst_mem_done", 32'(mem_done), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);

    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].is_mem, tbl[i].we, tbl[i].len, tbl[i].addr, tbl[i].wdata,
              tbl[i].exp_data, tbl[i].exp_lat);

    // Collision: store wins, fetch follows after the DONE/IDLE cycles.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h200; mem_wdata = 32'hDEADBEEF;
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        chk("col_we", 32'(ram_we), 32'd1);
        chk("col_addr", ram_addr, 32'h200 + c - 1);
        chk("col_wdata", 32'(ram_wdata), (32'hDEADBEEF >> (8 * (c - 1))) & 32'hFF);
      end
      if (c == 6) begin
        chk("col_idle_addr", ram_addr, 32'h0);
        chk("col_idle_we", 32'(ram_we), 32'h0);
      end
      if (c >= 7 && c <= 10) begin
        chk("col_if_addr", ram_addr, 32'h100 + c - 7);
        chk("col_if_we", 32'(ram_we), 32'h0);
      end
      if (c == 5) chk("col_stall", 32'(stall_o), 32'd1);
      chk("col_mem_done", 32'(mem_done), (c == 5) ? 32'd1 : 32'd0);
      chk("col_if_done", 32'(if_done), (c == 12) ? 32'd1 : 32'd0);
      if (c == 12) chk("col_if_data", if_data, 32'h0010_0513);
      @(posedge clk); #1;
      if (c == 5) mem_req = 1'b0;
    end
    if_req = 1'b0;
    model_write(32'h200, 32'hDEADBEEF, 4);
    exp_if = 32'h0010_0513;

    // Abort: fetch dropped in cycle 2, queued byte load granted in cycle 3.
    if_req = 1'b1; if_addr = 32'h300;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      chk("abort_if_done", 32'(if_done), 32'd0);
      chk("abort_if_data", if_data, exp_if);
      if (c == 4) chk("abort_mem_addr", ram_addr, 32'h40);
      chk("abort_mem_done", 32'(mem_done), (c == 6) ? 32'd1 : 32'd0);
      if (c == 6) chk("abort_mem_rdata", mem_rdata, 32'h80);
      @(posedge clk); #1;
      if (c == 1) begin
        if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h40;
      end
    end
    mem_req = 1'b0;
    exp_mem = 32'h80;

    // Randomized transactions against the memory model.
    for (int t = 0; t < 40; t++) begin
      bit          im, w;
      logic [1:0]  ln;
      logic [31:0] a, wd, ed;
      int unsigned n, lat;
      im = 1'($urandom_range(0, 1));
      w  = im & 1'($urandom_range(0, 1));
      ln = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom;
      wd = $urandom;
      n  = len_bytes(im, ln);
      lat = !im ? 6 : (w ? n + 1 : n + 2);
      ed  = w ? exp_mem : model_read(a, n);
      run_txn(im, w, ln, a, wd, ed, lat);
    end

    // Reset in the middle of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h500; mem_wdata = 32'h11223344;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs_we_c1", 32'(ram_we), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("rs_we_now", 32'(ram_we), 32'd0);
    chk("rs_addr_now", ram_addr, 32'h0);
    chk("rs_mem_done_now", 32'(mem_done), 32'd0);
    chk("rs_if_data_now", if_data, 32'h0);
    chk("rs_mem_rdata_now", mem_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rs_mem_done", 32'(mem_done), 32'd0);
      chk("rs_ram_we", 32'(ram_we), 32'd0);
      chk("rs_ram_addr", ram_addr, 32'h0);
      chk("rs_wdata", 32'(ram_wdata), 32'h0);
      chk("rs_if_data", if_data, 32'h0);
      chk("rs_mem_rdata", mem_rdata, 32'h0);
      chk("rs_stall", 32'(stall_o), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
